// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial result serializer.
//   state_t     : serializer FSM states
//   entry_t     : FIFO entry, operand tag plus 32-bit result word
//   FRAME_BYTES : header byte plus four data bytes
//   HDR_NIB_DEF : default upper nibble of the header byte
package fact_pkg;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    DATA
  } state_t;

  localparam int unsigned FRAME_BYTES = 5;
  localparam logic [3:0]  HDR_NIB_DEF = 4'hA;

  typedef struct packed {
    logic [3:0]  tag;
    logic [31:0] data;
  } entry_t;

endpackage

// File: rtl/fact_sync_fifo.sv
// Generic synchronous FIFO with first-word fall-through read.
//   clk, reset : rising-edge clock, synchronous active-high reset
//   push/wdata : write request; ignored while full
//   pop/rdata  : read request; rdata shows the head entry, ignored while empty
//   full/empty : status decoded from count
//   count      : number of stored entries (0..DEPTH)
module fact_sync_fifo #(
  parameter int unsigned WIDTH = 36,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fact_result_serializer.sv
// Buffers {tag, result} pairs from the factorial unit and emits each as a
// 5-byte frame (header {HDR_NIB, tag}, then result bytes MSB first) on a
// byte-wide valid/ready stream.
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   in_valid/in_ready     : input handshake; in_ready is low while reset is high
//   in_data, in_tag       : result word and the operand that produced it
//   out_valid/out_ready   : output byte handshake
//   out_data, out_last    : frame byte, high on the final byte of a frame
//   frame_count           : completed frames, wraps at 0xFFFF
module fact_result_serializer
  import fact_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = 32,
  parameter logic [3:0]  HDR_NIB = HDR_NIB_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic              out_last,
  output logic [15:0]       frame_count
);

  localparam int unsigned CW       = $clog2(DEPTH) + 1;
  localparam logic [1:0]  LAST_IDX = 2'(FRAME_BYTES - 2);

  state_t            state, state_n;
  entry_t            wentry, head;
  logic [DATA_W-1:0] shreg, shreg_n;
  logic [3:0]        tag_r, tag_n;
  logic [1:0]        idx, idx_n;
  logic [15:0]       fc_n;
  logic              valid_n, last_n;
  logic [7:0]        data_n;
  logic              push, pop, hs;
  logic              fifo_full, fifo_empty;
  logic [CW-1:0]     fifo_count;

  assign wentry.tag  = in_tag;
  assign wentry.data = in_data;
  assign in_ready    = !reset && (fifo_count != CW'(DEPTH));
  assign push        = in_valid && !reset && !fifo_full;
  assign hs          = out_valid && out_ready;

  fact_sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    tag_n   = tag_r;
    idx_n   = idx;
    fc_n    = frame_count;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_n = head.data;
          tag_n   = head.tag;
          state_n = HDR;
        end
      end
      HDR: begin
        if (hs) begin
          idx_n   = '0;
          state_n = DATA;
        end
      end
      DATA: begin
        if (hs) begin
          shreg_n = shreg << 8;
          idx_n   = idx + 2'd1;
          if (idx == LAST_IDX) begin
            fc_n  = frame_count + 16'd1;
            idx_n = '0;
            // Chain straight into the next header so frames leave back to back.
            if (!fifo_empty) begin
              pop     = 1'b1;
              shreg_n = head.data;
              tag_n   = head.tag;
              state_n = HDR;
            end else begin
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from next-state values so they can be registered.
    valid_n = (state_n != IDLE);
    last_n  = (state_n == DATA) && (idx_n == LAST_IDX);
    case (state_n)
      HDR:     data_n = {HDR_NIB, tag_n};
      DATA:    data_n = shreg_n[DATA_W-1 -: 8];
      default: data_n = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      tag_r       <= '0;
      idx         <= '0;
      frame_count <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_last    <= 1'b0;
    end else begin
      state       <= state_n;
      shreg       <= shreg_n;
      tag_r       <= tag_n;
      idx         <= idx_n;
      frame_count <= fc_n;
      out_valid   <= valid_n;
      out_data    <= data_n;
      out_last    <= last_n;
    end
  end

endmodule

// File: tb/tb_fact_result_serializer.sv
module tb_fact_result_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] frame_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_fc = 0;
  int bytes_seen = 0;

  logic [8:0] sb[$];   // expected {last, byte}

  always #5 clk = ~clk;

  fact_result_serializer #(
    .DEPTH   (4),
    .DATA_W  (32),
    .HDR_NIB (4'hA)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .frame_count (frame_count)
  );

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [39:0] mk_frame(input logic [3:0] t, input logic [31:0] d);
    return {4'hA, t, d};
  endfunction

  task automatic sb_push(input logic [39:0] f);
    for (int i = 0; i < 5; i++) sb.push_back({(i == 4), f[39 - 8*i -: 8]});
  endtask

  // Scoreboard and stall-stability monitor, sampled on the falling edge.
  logic       stalled = 1'b0;
  logic [8:0] held;
  always @(negedge clk) begin
    logic [8:0] e;
    if (reset) begin
      sb.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) check("stall_hold", {30'd0, out_valid, out_last, out_data}, {30'd0, 1'b1, held});
      if (out_valid && out_ready) begin
        bytes_seen++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_byte: got 0x%0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          check("byte", {31'd0, out_last, out_data}, {31'd0, e});
        end
      end
      stalled = out_valid && !out_ready;
      held    = {out_last, out_data};
    end
  end

  // Ready pattern 1,0,0,1 for the backpressure sequence.
  logic bp_on = 1'b0;
  int   bp_k  = 0;
  always @(posedge clk) begin
    if (bp_on) begin
      #1;
      out_ready = (bp_k % 4 == 0) || (bp_k % 4 == 3);
      bp_k++;
    end
  end

  // Returns 1 ns after the accepting edge with in_valid dropped.
  task automatic push_word(input logic [3:0] t, input logic [31:0] d, input logic [39:0] f);
    bit ok = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_tag   = t;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb_push(f);
        ok = 1;
        break;
      end
    end
    if (!ok) timeout("push_accept");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) return;
    end
    timeout(name);
  endtask

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] data;
    logic [39:0] frame;
  } vec_t;

  vec_t vecs[4];

  initial begin
    int cnt;
    int base;
    bit ok;

    vecs[0] = '{4'h5, 32'h0000_00F0, 40'hA5_00_00_00_F0};
    vecs[1] = '{4'h0, 32'hDEAD_BEEF, 40'hA0_DE_AD_BE_EF};
    vecs[2] = '{4'hF, 32'h0123_4567, 40'hAF_01_23_45_67};
    vecs[3] = '{4'h9, 32'hFFFF_FFFF, 40'hA9_FF_FF_FF_FF};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_tag = '0; in_data = '0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {39'd0, in_ready}, 40'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {39'd0, out_valid}, 40'd0);
    check("rst_out_last", {39'd0, out_last}, 40'd0);
    check("rst_out_data", {32'd0, out_data}, 40'd0);
    check("rst_frame_count", {24'd0, frame_count}, 40'd0);
    check("rst_in_ready_after", {39'd0, in_ready}, 40'd1);

    // Single frames with latency check: header visible two cycles after push cycle.
    out_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      push_word(vecs[v].tag, vecs[v].data, vecs[v].frame);
      @(negedge clk);
      check("lat_t1_idle", {39'd0, out_valid}, 40'd0);
      @(negedge clk);
      check("lat_t2_valid", {39'd0, out_valid}, 40'd1);
      check("lat_t2_hdr", {32'd0, out_data}, {32'd0, vecs[v].frame[39:32]});
      wait_drain("single_drain");
      exp_fc++;
      check("single_fc", {24'd0, frame_count}, 40'(16'(exp_fc)));
    end

    // Backpressure: ready toggles 1,0,0,1; monitor checks hold and order.
    bp_on = 1'b1;
    push_word(4'h5, 32'h0000_00F0, mk_frame(4'h5, 32'h0000_00F0));
    wait_drain("bp_drain");
    bp_on = 1'b0;
    @(posedge clk); #1 out_ready = 1'b0;
    exp_fc++;
    check("bp_fc", {24'd0, frame_count}, 40'(16'(exp_fc)));

    // Fill with consumer stalled: 4 FIFO entries plus one held in the shift register.
    for (int t = 1; t <= 5; t++)
      push_word(4'(t), 32'h1000_0000 * t, mk_frame(4'(t), 32'h1000_0000 * t));
    @(posedge clk); #1;
    in_valid = 1'b1; in_tag = 4'h6; in_data = 32'h6666_6666;
    repeat (3) begin
      @(negedge clk);
      check("fill_full", {39'd0, in_ready}, 40'd0);
    end
    fork
      begin
        @(posedge clk); #1 out_ready = 1'b1;
        cnt = 0;
        repeat (30) begin
          @(negedge clk);
          if (out_valid) cnt++;
        end
        check("fill_no_gap", 40'(cnt), 40'd30);
      end
      begin
        ok = 0;
        for (int i = 0; i < 100; i++) begin
          @(negedge clk);
          if (in_ready) begin
            sb_push(mk_frame(4'h6, 32'h6666_6666));
            ok = 1;
            break;
          end
        end
        if (!ok) timeout("fill_6th_accept");
        @(posedge clk); #1 in_valid = 1'b0;
      end
    join
    wait_drain("fill_drain");
    exp_fc += 6;
    check("fill_fc", {24'd0, frame_count}, 40'(16'(exp_fc)));

    // Back-to-back: 15 consecutive valid bytes.
    fork
      begin
        push_word(4'h1, 32'hA1A2_A3A4, mk_frame(4'h1, 32'hA1A2_A3A4));
        push_word(4'h2, 32'hB1B2_B3B4, mk_frame(4'h2, 32'hB1B2_B3B4));
        push_word(4'h3, 32'hC1C2_C3C4, mk_frame(4'h3, 32'hC1C2_C3C4));
      end
      begin
        ok = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (out_valid) begin ok = 1; break; end
        end
        if (!ok) timeout("b2b_start");
        cnt = 1;
        repeat (14) begin
          @(negedge clk);
          if (out_valid) cnt++;
        end
        check("b2b_contig", 40'(cnt), 40'd15);
        @(negedge clk);
        check("b2b_end", {39'd0, out_valid}, 40'd0);
      end
    join
    wait_drain("b2b_drain");
    exp_fc += 3;
    check("b2b_fc", {24'd0, frame_count}, 40'(16'(exp_fc)));

    // Reset after the second data byte is taken.
    base = bytes_seen;
    fork
      push_word(4'h7, 32'h7172_7374, mk_frame(4'h7, 32'h7172_7374));
      begin
        ok = 0;
        for (int i = 0; i < 50; i++) begin
          @(negedge clk);
          if (bytes_seen == base + 3) begin ok = 1; break; end
        end
        if (!ok) timeout("mid_wait");
      end
    join
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", {39'd0, in_ready}, 40'd0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("mid_out_valid", {39'd0, out_valid}, 40'd0);
    check("mid_fc", {24'd0, frame_count}, 40'd0);
    check("mid_in_ready", {39'd0, in_ready}, 40'd1);
    repeat (3) begin
      @(negedge clk);
      check("mid_no_resume", {39'd0, out_valid}, 40'd0);
    end
    exp_fc = 0;
    push_word(4'h8, 32'h8182_8384, mk_frame(4'h8, 32'h8182_8384));
    wait_drain("mid_drain");
    exp_fc++;
    check("mid_after_fc", {24'd0, frame_count}, 40'(16'(exp_fc)));

    // Counter wrap from a preloaded 0xFFFF.
    @(negedge clk);
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    @(negedge clk);
    check("wrap_pre", {24'd0, frame_count}, 40'h0_0000_FFFF);
    push_word(4'h2, 32'h0000_0002, mk_frame(4'h2, 32'h0000_0002));
    wait_drain("wrap_drain");
    check("wrap_post", {24'd0, frame_count}, 40'd0);

    check("sb_empty", 40'(sb.size()), 40'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
